// File: rtl/mips_dmem_ctrl.sv
// mips_dmem_ctrl: four byte-lane data memory with valid/ready requests and a registered response.
// Define MIPS_DMEM_ALIGN_CHECK_EN to reject misaligned accesses with MemErr.
module mips_dmem_ctrl #(
  parameter int ADDR_BITS = 12,
  parameter int READ_PIPE = 0
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        MemWrite,
  input  logic [1:0]  Size,
  input  logic        Unsigned,
  input  logic [31:0] AluResult,
  input  logic [31:0] WriteData,
  output logic        RespValid,
  output logic [31:0] MemReadData,
  output logic        MemErr
);
  localparam int IW    = ADDR_BITS - 2;
  localparam int DEPTH = 1 << IW;

  logic [31:0]   mem [DEPTH];
  logic [IW-1:0] idx;
  logic [1:0]    off;
  logic          acc;
  logic          mis;
  logic          wen;
  logic [3:0]    lanes;
  logic [31:0]   wdat;
  logic [31:0]   rword;
  logic          unused_hi;

  logic          byp_v;
  logic [IW-1:0] byp_idx;
  logic [3:0]    byp_lanes;
  logic [31:0]   byp_dat;

  logic          s1_v;
  logic          s1_st;
  logic          s1_err;
  logic [1:0]    s1_size;
  logic [1:0]    s1_off;
  logic          s1_uns;
  logic [31:0]   s1_word;

  logic [7:0]    b_sel;
  logic [15:0]   h_sel;
  logic [31:0]   ext;
  logic [31:0]   rdata;

  assign idx       = AluResult[ADDR_BITS-1:2];
  assign off       = AluResult[1:0];
  assign unused_hi = ^AluResult[31:ADDR_BITS];
  assign acc       = ReqValid & ReqReady & RST_N;
  assign wen       = acc & MemWrite & ~mis;

`ifdef MIPS_DMEM_ALIGN_CHECK_EN
  always_comb begin
    mis = 1'b1;
    unique case (1'b1)
      Size == 2'b00: mis = 1'b0;
      Size == 2'b01: mis = off[0];
      Size == 2'b10: mis = |off;
      default:       mis = 1'b1;
    endcase
  end
`else
  assign mis = 1'b0;
`endif

  // Narrow stores replicate their data so each lane just picks its byte.
  always_comb begin
    lanes = 4'b1111;
    wdat  = WriteData;
    unique case (1'b1)
      Size == 2'b00: begin
        lanes = 4'b0001 << off;
        wdat  = {4{WriteData[7:0]}};
      end
      Size == 2'b01: begin
        lanes = off[1] ? 4'b1100 : 4'b0011;
        wdat  = {2{WriteData[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (wen) begin
      for (int k = 0; k < 4; k++) begin
        if (lanes[k]) mem[idx][8*k +: 8] <= wdat[8*k +: 8];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      byp_v <= 1'b0;
    end else if (wen) begin
      byp_v     <= 1'b1;
      byp_idx   <= idx;
      byp_lanes <= lanes;
      byp_dat   <= wdat;
    end
  end

  always_comb begin
    rword = mem[idx];
    for (int k = 0; k < 4; k++) begin
      if (byp_v && byp_idx == idx && byp_lanes[k])
        rword[8*k +: 8] = byp_dat[8*k +: 8];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      ReqReady <= 1'b0;
      s1_v     <= 1'b0;
      s1_st    <= 1'b0;
      s1_err   <= 1'b0;
    end else begin
      ReqReady <= 1'b1;
      s1_v     <= acc;
      if (acc) begin
        s1_st   <= MemWrite;
        s1_err  <= mis;
        s1_size <= Size;
        s1_off  <= off;
        s1_uns  <= Unsigned;
        s1_word <= rword;
      end
    end
  end

  always_comb begin
    b_sel = s1_word[8*s1_off +: 8];
    h_sel = s1_off[1] ? s1_word[31:16] : s1_word[15:0];
    ext   = s1_word;
    unique case (1'b1)
      s1_size == 2'b00: ext = {{24{b_sel[7] & ~s1_uns}}, b_sel};
      s1_size == 2'b01: ext = {{16{h_sel[15] & ~s1_uns}}, h_sel};
      default:          ext = s1_word;
    endcase
    rdata = (s1_v && !s1_st && !s1_err) ? ext : 32'd0;
  end

  generate
    if (READ_PIPE == 0) begin : g_p0
      assign RespValid   = s1_v;
      assign MemErr      = s1_v & s1_err;
      assign MemReadData = rdata;
    end else begin : g_p1
      always_ff @(posedge CLK) begin
        if (!RST_N) begin
          RespValid   <= 1'b0;
          MemErr      <= 1'b0;
          MemReadData <= 32'd0;
        end else begin
          RespValid   <= s1_v;
          MemErr      <= s1_v & s1_err;
          MemReadData <= rdata;
        end
      end
    end
  endgenerate
endmodule

// File: tb/tb_mips_dmem_ctrl.sv
// tb_mips_dmem_ctrl: byte-array reference model driving both READ_PIPE variants
// with directed and random requests.
module tb_mips_dmem_ctrl;
  logic        CLK = 1'b0;
  logic        RST_N;
  logic        ReqValid;
  logic        MemWrite;
  logic [1:0]  Size;
  logic        Unsigned;
  logic [31:0] AluResult;
  logic [31:0] WriteData;

  logic        rdy0, rv0, er0;
  logic [31:0] d0;
  logic        rdy1, rv1, er1;
  logic [31:0] d1;

  typedef struct packed {
    logic        v;
    logic        err;
    logic [31:0] d;
  } rsp_t;

  logic [7:0] mm [4096];
  rsp_t exp0, exp1;
  logic rdy_m;
  int   total, bad, pulses1;

  always #5 CLK = ~CLK;

  mips_dmem_ctrl #(.ADDR_BITS(12), .READ_PIPE(0)) u0 (
    .CLK(CLK), .RST_N(RST_N), .ReqValid(ReqValid), .ReqReady(rdy0),
    .MemWrite(MemWrite), .Size(Size), .Unsigned(Unsigned),
    .AluResult(AluResult), .WriteData(WriteData),
    .RespValid(rv0), .MemReadData(d0), .MemErr(er0)
  );

  mips_dmem_ctrl #(.ADDR_BITS(12), .READ_PIPE(1)) u1 (
    .CLK(CLK), .RST_N(RST_N), .ReqValid(ReqValid), .ReqReady(rdy1),
    .MemWrite(MemWrite), .Size(Size), .Unsigned(Unsigned),
    .AluResult(AluResult), .WriteData(WriteData),
    .RespValid(rv1), .MemReadData(d1), .MemErr(er1)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, expv);
    end
  endtask

  // Memory as a flat byte array, aliased on the low 12 address bits.
  task automatic model(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       output rsp_t r);
    int nb, base;
    logic [31:0] val, mask;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    base = int'(a[11:0]);
    r.v = 1'b1;
    r.d = 32'd0;
`ifdef MIPS_DMEM_ALIGN_CHECK_EN
    r.err = (sz == 2'd3) || (base % nb != 0);
`else
    r.err = 1'b0;
    base = base - base % nb;
`endif
    if (!r.err) begin
      if (we) begin
        for (int i = 0; i < nb; i++) mm[base+i] = wd[8*i +: 8];
      end else begin
        val = 32'd0;
        for (int i = 0; i < nb; i++) val[8*i +: 8] = mm[base+i];
        if (nb < 4) begin
          mask = (32'd1 << (8*nb)) - 32'd1;
          if (!uns && val[8*nb-1]) val = val | ~mask;
        end
        r.d = val;
      end
    end
  endtask

  task automatic step(input logic rst, input logic rv, input logic we,
                      input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd);
    rsp_t r;
    RST_N = rst; ReqValid = rv; MemWrite = we; Size = sz;
    Unsigned = uns; AluResult = a; WriteData = wd;
    @(posedge CLK);
    r = '0;
    if (rst && rv && rdy_m) model(we, sz, uns, a, wd, r);
    exp1 = rst ? exp0 : '0;
    exp0 = r;
    rdy_m = rst;
    #1;
    chk("ready0", {31'd0, rdy0}, {31'd0, rdy_m});
    chk("ready1", {31'd0, rdy1}, {31'd0, rdy_m});
    chk("valid0", {31'd0, rv0}, {31'd0, exp0.v});
    chk("err0", {31'd0, er0}, {31'd0, exp0.err});
    chk("data0", d0, exp0.d);
    chk("valid1", {31'd0, rv1}, {31'd0, exp1.v});
    chk("err1", {31'd0, er1}, {31'd0, exp1.err});
    chk("data1", d1, exp1.d);
    if (rv1 === 1'b1) pulses1++;
  endtask

  task automatic idle(input logic rst);
    step(rst, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    total = 0; bad = 0; pulses1 = 0;
    rdy_m = 1'b0; exp0 = '0; exp1 = '0;

    idle(1'b0); idle(1'b0); idle(1'b0);
    idle(1'b1);
    chk("ready_after_rst", {31'd0, rdy0}, 32'd1);

    for (int i = 0; i < 64; i++)
      step(1'b1, 1'b1, 1'b1, 2'd2, 1'b0, i * 4, $urandom());

    step(1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 32'h10, 32'h12345678);
    chk("sw_data", d0, 32'd0);
    step(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
    chk("lw_bypass", d0, 32'h12345678);

    step(1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 32'h11, 32'h000000AB);
    step(1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 32'h11, 32'd0);
    chk("lbu", d0, 32'h000000AB);
    step(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 32'h11, 32'd0);
    chk("lb", d0, 32'hFFFFFFAB);
    step(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
    chk("lw_after_sb", d0, 32'h1234AB78);

    step(1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 32'h12, 32'h00008001);
    step(1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 32'h12, 32'd0);
    chk("lh", d0, 32'hFFFF8001);
    step(1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 32'h12, 32'd0);
    chk("lhu", d0, 32'h00008001);
    step(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
    chk("lw_after_sh", d0, 32'h8001AB78);

    step(1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 32'h13, 32'hDEADBEEF);
`ifdef MIPS_DMEM_ALIGN_CHECK_EN
    chk("mis_err", {31'd0, er0}, 32'd1);
    step(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
    chk("mis_lw", d0, 32'h8001AB78);
`else
    chk("mis_err", {31'd0, er0}, 32'd0);
    step(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
    chk("mis_lw", d0, 32'hDEADBEEF);
`endif

    step(1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 32'h1010, 32'h55AA55AA);
    step(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h010, 32'd0);
    chk("alias_p0", d0, 32'h55AA55AA);
    idle(1'b1);
    chk("alias_p1", d1, 32'h55AA55AA);

    step(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'd0);
    step(1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 32'h24, 32'hCAFEF00D);
    chk("rst_valid1", {31'd0, rv1}, 32'd0);
    chk("rst_ready", {31'd0, rdy0}, 32'd0);
    step(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h24, 32'd0);
    chk("rst_rel_valid1", {31'd0, rv1}, 32'd0);
    step(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h24, 32'd0);
    idle(1'b1); idle(1'b1);

    pulses1 = 0;
    for (int i = 0; i < 8; i++)
      step(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h40 + i * 4, 32'd0);
    idle(1'b1);
    chk("b2b_pulses", pulses1, 32'd8);

    for (int i = 0; i < 400; i++) begin
      a = ($urandom() & 32'hFFFFF000) | 32'($urandom_range(0, 255));
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0),
           1'($urandom()), 2'($urandom()), 1'($urandom()), a, $urandom());
    end
    idle(1'b1); idle(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
